// File: rtl/rcc_reg_pkg.sv
// Shared types and constants for the RCC register-bus initiator and its users.
package rcc_reg_pkg;

  // Default bus geometry, used where a module has no data-width parameter of its own.
  localparam int DEF_DW = 32;
  localparam int DEF_WW = DEF_DW / 8;

  // Number of byte-offset address bits that must be zero for an aligned access.
  localparam int ALIGN_LSB = $clog2(DEF_WW);

  // Initiator FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } rcc_state_e;

  // Response classification for benches and scoreboards.
  typedef enum logic [1:0] {
    RSP_OK       = 2'd0,
    RSP_SLVERR   = 2'd1,
    RSP_MISALIGN = 2'd2,
    RSP_TIMEOUT  = 2'd3
  } rcc_rsp_code_e;

  // Alignment LSB count for an arbitrary strobe width; a one-byte bus has no offset bits.
  function automatic int alignLsb(input int ww);
    return (ww > 1) ? $clog2(ww) : 0;
  endfunction

endpackage

// File: rtl/rcc_timeout_cnt.sv
// Parameterised saturating cycle counter that flags when a wait has run its full budget.
// LIMIT = 0 disables expiry altogether.
module rcc_timeout_cnt #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((LIMIT > 0) ? (LIMIT - 1) : 0);
  localparam logic [CW-1:0] SAT  = CW'(LIMIT);

  logic [CW-1:0] cnt_q;

  // Count enabled cycles, holding at LIMIT rather than wrapping back to zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != SAT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (LIMIT > 0) && (cnt_q == LAST);

endmodule

// File: rtl/rcc_reg_master.sv
// Single-outstanding register-bus initiator for the RCC slave interface.
// Commands arrive over valid/ready, one bus transaction is issued at a time,
// and every request is bounded by a timeout so a dead slave cannot stall the source.
module rcc_reg_master
  import rcc_reg_pkg::*;
#(
  parameter int AW             = 29,
  parameter int DW             = 32,
  parameter int WW             = DW / 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ALIGN_CHECK    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [WW-1:0] cmd_wstrb,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic [WW-1:0] bus_wstrb,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_err,
  output logic          busy
);

  localparam int LSB = alignLsb(WW);
  localparam logic [AW-1:0] ALIGN_MASK = AW'((1 << LSB) - 1);

  rcc_state_e    state_q;
  logic          busReq_q;
  logic          busWe_q;
  logic [AW-1:0] busAddr_q;
  logic [DW-1:0] busWdata_q;
  logic [WW-1:0] busWstrb_q;
  logic          rspValid_q;
  logic [DW-1:0] rspRdata_q;
  logic          rspErr_q;
  logic          rspTimeout_q;
  logic          busy_q;

  logic cmdMisaligned;
  logic cmdEmptyWrite;
  logic tmoExpired;

  assign cmdMisaligned = (ALIGN_CHECK != 0) && ((cmd_addr & ALIGN_MASK) != '0);
  assign cmdEmptyWrite = cmd_we && (cmd_wstrb == '0);

  // The wait budget only runs while a request is outstanding and unanswered.
  rcc_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q != REQ),
    .en     (busReq_q && !bus_ack),
    .expired(tmoExpired)
  );

  // Transaction sequencer: capture a command, run it on the bus, hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busReq_q     <= 1'b0;
      busWe_q      <= 1'b0;
      busAddr_q    <= '0;
      busWdata_q   <= '0;
      busWstrb_q   <= '0;
      rspValid_q   <= 1'b0;
      rspRdata_q   <= '0;
      rspErr_q     <= 1'b0;
      rspTimeout_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            busWe_q      <= cmd_we;
            busAddr_q    <= cmd_addr;
            busWdata_q   <= cmd_wdata;
            busWstrb_q   <= cmd_we ? cmd_wstrb : '0;
            rspRdata_q   <= '0;
            rspErr_q     <= 1'b0;
            rspTimeout_q <= 1'b0;
            busy_q       <= 1'b1;
            if (cmdMisaligned) begin
              rspErr_q   <= 1'b1;
              rspValid_q <= 1'b1;
              state_q    <= RESP;
            end else if (cmdEmptyWrite) begin
              rspValid_q <= 1'b1;
              state_q    <= RESP;
            end else begin
              busReq_q <= 1'b1;
              state_q  <= REQ;
            end
          end
        end
        REQ: begin
          if (bus_ack) begin
            rspRdata_q <= busWe_q ? '0 : bus_rdata;
            rspErr_q   <= bus_err;
            busReq_q   <= 1'b0;
            rspValid_q <= 1'b1;
            state_q    <= RESP;
          end else if (tmoExpired) begin
            rspRdata_q   <= '0;
            rspErr_q     <= 1'b1;
            rspTimeout_q <= 1'b1;
            busReq_q     <= 1'b0;
            rspValid_q   <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rspValid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          busReq_q   <= 1'b0;
          rspValid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign bus_req     = busReq_q;
  assign bus_we      = busWe_q;
  assign bus_addr    = busAddr_q;
  assign bus_wdata   = busWdata_q;
  assign bus_wstrb   = busWstrb_q;
  assign rsp_valid   = rspValid_q;
  assign rsp_rdata   = rspRdata_q;
  assign rsp_err     = rspErr_q;
  assign rsp_timeout = rspTimeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_rcc_reg_master.sv
// Directed scoreboard bench for the RCC register-bus initiator.
module tb_rcc_reg_master;
  import rcc_reg_pkg::*;

  localparam int AW = 29;
  localparam int DW = 32;
  localparam int WW = DW / 8;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [WW-1:0] cmd_wstrb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [WW-1:0] bus_wstrb;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;
  logic          bus_err;
  logic          busy;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } exp_t;

  exp_t sb[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  rcc_reg_master #(
    .AW(AW), .DW(DW), .WW(WW), .TIMEOUT_CYCLES(TMO), .ALIGN_CHECK(1)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .busy(busy)
  );

  // Free-running block clock.
  always #5 clk = ~clk;

  // Advance one edge and settle just after it, away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one command for a single cycle and record the response it should produce.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [WW-1:0] wstrb,
                               input logic [DW-1:0] expRdata, input logic expErr,
                               input logic expTmo);
    exp_t e;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wstrb = wstrb;
    check("cmdReadyIdle", cmd_ready, 1'b1);
    e.rdata = expRdata;
    e.err   = expErr;
    e.tmo   = expTmo;
    sb.push_back(e);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Compare the currently presented response with the oldest scoreboard entry.
  task automatic compareRsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sbEmpty"}, 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      check({tag, "_rdata"}, rsp_rdata, e.rdata);
      check({tag, "_err"}, rsp_err, e.err);
      check({tag, "_tmo"}, rsp_timeout, e.tmo);
    end
  endtask

  // Wait (bounded) for a response, score it, then consume it.
  task automatic checkOutput(input string tag);
    int n = 0;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_rspValid"}, rsp_valid, 1'b1);
    compareRsp(tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_rspDone"}, rsp_valid, 1'b0);
    check({tag, "_backIdle"}, cmd_ready, 1'b1);
  endtask

  initial begin
    int n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b0; bus_ack = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    tick();
    tick();
    check("rst_busReq", bus_req, 1'b0);
    check("rst_rspValid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_busAddr", bus_addr, '0);
    check("rst_cmdReady", cmd_ready, 1'b1);
    rst = 1'b0;
    tick();

    // Write, slave acks three cycles after the request starts.
    applyStimulus(1'b1, 29'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus_req) n++;
      check("wr_busAddr", bus_addr, 29'h10);
      check("wr_busWdata", bus_wdata, 32'hDEAD_BEEF);
      check("wr_busWstrb", bus_wstrb, 4'hF);
      check("wr_busWe", bus_we, 1'b1);
      check("wr_cmdReady", cmd_ready, 1'b0);
      tick();
    end
    if (bus_req) n++;
    bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    tick();
    bus_ack = 1'b0; bus_rdata = '0;
    check("wr_reqCycles", n, 4);
    check("wr_reqDropped", bus_req, 1'b0);
    check("wr_rspNext", rsp_valid, 1'b1);
    checkOutput("wr");

    // Read with same-cycle ack and rsp_ready held high: three-cycle turnaround.
    rsp_ready = 1'b1;
    applyStimulus(1'b0, 29'h4, 32'hFFFF_FFFF, 4'hF, 32'h1234_5678, 1'b0, 1'b0);
    check("rd_busReq", bus_req, 1'b1);
    check("rd_busWstrb", bus_wstrb, 4'h0);
    check("rd_busWe", bus_we, 1'b0);
    check("rd_cmdReady1", cmd_ready, 1'b0);
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    bus_ack = 1'b0; bus_rdata = '0;
    check("rd_rspValid", rsp_valid, 1'b1);
    check("rd_cmdReady2", cmd_ready, 1'b0);
    compareRsp("rd");
    tick();
    check("rd_cmdReady3", cmd_ready, 1'b1);
    check("rd_rspCleared", rsp_valid, 1'b0);
    rsp_ready = 1'b0;

    // Read with no ack: times out after exactly TMO request cycles.
    applyStimulus(1'b0, 29'h8, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    n = 0;
    while (bus_req && n < 200) begin
      n++;
      tick();
    end
    check("tmo_reqCycles", n, TMO);
    check("tmo_rspValid", rsp_valid, 1'b1);
    tick();
    tick();
    bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0; bus_err = 1'b0;
    tick();
    bus_ack = 1'b0; bus_rdata = '0;
    check("tmo_lateAckReq", bus_req, 1'b0);
    check("tmo_lateAckBusy", busy, 1'b1);
    checkOutput("tmo");

    // Misaligned access, then an empty-strobe write: neither touches the bus.
    applyStimulus(1'b0, 29'h6, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    check("mis_noReq", bus_req, 1'b0);
    checkOutput("mis");
    applyStimulus(1'b1, 29'h20, 32'hA5A5_A5A5, 4'h0, 32'h0, 1'b0, 1'b0);
    check("nostrb_noReq", bus_req, 1'b0);
    checkOutput("nostrb");

    // Slave error with the response held off for five cycles.
    applyStimulus(1'b1, 29'h30, 32'h0000_00FF, 4'h1, 32'h0, 1'b1, 1'b0);
    bus_ack = 1'b1; bus_err = 1'b1;
    tick();
    bus_ack = 1'b0; bus_err = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("serr_holdValid", rsp_valid, 1'b1);
      check("serr_holdErr", rsp_err, 1'b1);
      check("serr_holdCmdReady", cmd_ready, 1'b0);
      tick();
    end
    checkOutput("serr");

    // Reset during REQ abandons the transaction without a response.
    applyStimulus(1'b0, 29'h44, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    void'(sb.pop_back());
    tick();
    check("rstReq_reqHigh", bus_req, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstReq_busReq", bus_req, 1'b0);
    check("rstReq_busAddr", bus_addr, '0);
    check("rstReq_busWe", bus_we, 1'b0);
    check("rstReq_busWdata", bus_wdata, '0);
    check("rstReq_busWstrb", bus_wstrb, '0);
    check("rstReq_rspRdata", rsp_rdata, '0);
    check("rstReq_rspErr", rsp_err, 1'b0);
    check("rstReq_rspTmo", rsp_timeout, 1'b0);
    check("rstReq_busy", busy, 1'b0);
    tick();
    check("rstReq_noRsp", rsp_valid, 1'b0);
    applyStimulus(1'b0, 29'h48, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 1'b0);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    tick();
    bus_ack = 1'b0; bus_rdata = '0;
    checkOutput("postRst");

    check("sbDrained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
